// File: rtl/ysyx_23060332_axil_sram.sv
// AXI4-Lite responder backed by a synchronous word-addressed RAM, with independent read and write channels.
// Latency: rvalid RD_LAT+1 edges after the AR handshake; bvalid WR_LAT edges after both AW and W are captured.
// Backpressure: one outstanding transaction per channel; rvalid/bvalid and their payloads hold until rready/bready.
//
// Ports:
//   clk, rst                         clock and synchronous active-low reset
//   araddr/arvalid/arready           read address channel
//   rdata/rresp/rvalid/rready        read data channel (rresp 00 OKAY, 10 SLVERR)
//   awaddr/awvalid/awready           write address channel
//   wdata/wstrb/wvalid/wready        write data channel, one strobe bit per byte
//   bresp/bvalid/bready              write response channel
// All outputs come straight from flops. RAM contents survive reset.
module ysyx_23060332_axil_sram #(
    parameter int                 ADDR_W    = 32,
    parameter int                 DATA_W    = 64,
    parameter int                 DEPTH     = 4096,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = 32'h8000_0000,
    parameter int                 RD_LAT    = 1,
    parameter int                 WR_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready
);

    localparam int STRB_W  = DATA_W / 8;
    localparam int OFF_W   = $clog2(STRB_W);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    // Size of the mapped window in bytes; one bit wider than the address so
    // the comparison cannot wrap.
    localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH * STRB_W);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ({1'b0, off} < SPAN);
    endfunction

    // Low byte-offset bits are simply dropped: no misalignment error.
    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> OFF_W);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    r_state_t            r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_pend;

    w_state_t            w_state;
    logic [CNT_W-1:0]    w_cnt;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_data_q;
    logic [STRB_W-1:0]   w_strb_q;
    logic                aw_got;
    logic                w_got;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   ram_q;

    logic                r_ok;
    logic                w_ok;
    logic                ram_re;
    logic                ram_we;
    logic                aw_hs;
    logic                w_hs;

    assign r_ok  = in_range(r_addr);
    assign w_ok  = in_range(w_addr);
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // The RAM read is launched when the read countdown expires; the RAM's
    // output register is then copied to rdata on the following edge.
    assign ram_re = (r_state == R_WAIT) && !r_pend && (r_cnt == '0) && r_ok;

    // A reset on the commit edge suppresses the write.
    assign ram_we = rst && (w_state == W_WAIT) && (w_cnt == '0) && w_ok;

    // ------------------------------------------------------------------
    // RAM: read port and write port in one block so a same-word read and
    // write on the same edge returns the old contents.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (ram_re) begin
            ram_q <= mem[word_idx(r_addr)];
        end
        if (ram_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (w_strb_q[i]) begin
                    mem[word_idx(w_addr)][i*8 +: 8] <= w_data_q[i*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= R_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_pend  <= 1'b0;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        r_addr  <= araddr;
                        r_cnt   <= CNT_W'(RD_LAT - 1);
                        r_pend  <= 1'b0;
                        arready <= 1'b0;
                        r_state <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_pend) begin
                        // RAM output register is valid now.
                        rdata   <= r_ok ? ram_q : '0;
                        rresp   <= r_ok ? RESP_OKAY : RESP_SLVERR;
                        rvalid  <= 1'b1;
                        r_pend  <= 1'b0;
                        r_state <= R_RESP;
                    end else if (r_cnt == '0) begin
                        r_pend <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                R_RESP: begin
                    // arready returns only after the R handshake, so a new AR
                    // can never be accepted on the same edge.
                    if (rready) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write channel FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state  <= W_IDLE;
            w_cnt    <= '0;
            w_addr   <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            awready  <= 1'b1;
            wready   <= 1'b1;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    // AW and W are captured independently, in any order.
                    if (aw_hs) begin
                        w_addr  <= awaddr;
                        aw_got  <= 1'b1;
                        awready <= 1'b0;
                    end
                    if (w_hs) begin
                        w_data_q <= wdata;
                        w_strb_q <= wstrb;
                        w_got    <= 1'b1;
                        wready   <= 1'b0;
                    end
                    // Start counting on the edge that completes the pair.
                    if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                        w_cnt   <= CNT_W'(WR_LAT - 1);
                        w_state <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (w_cnt == '0) begin
                        // RAM commit happens on this same edge via ram_we.
                        bvalid  <= 1'b1;
                        bresp   <= w_ok ? RESP_OKAY : RESP_SLVERR;
                        w_state <= W_RESP;
                    end else begin
                        w_cnt <= w_cnt - CNT_W'(1);
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        aw_got  <= 1'b0;
                        w_got   <= 1'b0;
                        w_state <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060332_axil_sram.sv
// Bench for ysyx_23060332_axil_sram: two instances (fast and slow latency)
// driven by read/write transaction tasks; expected responses are queued when
// a transaction is issued and compared when the DUT responds.
module tb_ysyx_23060332_axil_sram;

    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          RDL0  = 1;
    localparam int          WRL0  = 1;
    localparam int          RDL1  = 3;
    localparam int          WRL1  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     [2];
    logic [31:0] araddr  [2];
    logic        arvalid [2];
    logic        arready [2];
    logic [63:0] rdata   [2];
    logic [1:0]  rresp   [2];
    logic        rvalid  [2];
    logic        rready  [2];
    logic [31:0] awaddr  [2];
    logic        awvalid [2];
    logic        awready [2];
    logic [63:0] wdata   [2];
    logic [7:0]  wstrb   [2];
    logic        wvalid  [2];
    logic        wready  [2];
    logic [1:0]  bresp   [2];
    logic        bvalid  [2];
    logic        bready  [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ysyx_23060332_axil_sram #(
            .ADDR_W    (32),
            .DATA_W    (64),
            .DEPTH     (DEPTH),
            .BASE_ADDR (BASE),
            .RD_LAT    ((g == 0) ? RDL0 : RDL1),
            .WR_LAT    ((g == 0) ? WRL0 : WRL1)
        ) u_dut (
            .clk     (clk),
            .rst     (rst[g]),
            .araddr  (araddr[g]),
            .arvalid (arvalid[g]),
            .arready (arready[g]),
            .rdata   (rdata[g]),
            .rresp   (rresp[g]),
            .rvalid  (rvalid[g]),
            .rready  (rready[g]),
            .awaddr  (awaddr[g]),
            .awvalid (awvalid[g]),
            .awready (awready[g]),
            .wdata   (wdata[g]),
            .wstrb   (wstrb[g]),
            .wvalid  (wvalid[g]),
            .wready  (wready[g]),
            .bresp   (bresp[g]),
            .bvalid  (bvalid[g]),
            .bready  (bready[g])
        );
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    typedef struct {
        logic [1:0] resp;
    } wr_exp_t;

    rd_exp_t     rd_q [$];
    wr_exp_t     wr_q [$];
    logic [63:0] model [int];

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(DEPTH * 8));
    endfunction

    function automatic int key(input int d, input logic [31:0] a);
        return d * DEPTH + int'((a - BASE) >> 3);
    endfunction

    function automatic logic [63:0] exp_rd(input int d, input logic [31:0] a);
        if (!in_rng(a)) return 64'h0;
        return model[key(d, a)];
    endfunction

    function automatic logic [1:0] exp_rr(input logic [31:0] a);
        return in_rng(a) ? 2'b00 : 2'b10;
    endfunction

    // Read transaction. Starts and ends #1 after a rising edge.
    task automatic rd_txn(input int d, input logic [31:0] a, input logic [63:0] exp_d,
                          input logic [1:0] exp_r, input int bp, input bit chk_lat);
        rd_exp_t     e;
        logic [63:0] held;
        int          n;
        e.data = exp_d;
        e.resp = exp_r;
        rd_q.push_back(e);
        araddr[d]  = a;
        arvalid[d] = 1'b1;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (arready[d]) break;
            n++;
        end
        @(posedge clk);
        #1;
        arvalid[d] = 1'b0;
        chk("ar_accept_timeout", 64'(n < 100), 64'd1);
        chk("arready_drop", 64'(arready[d]), 64'd0);
        n = 0;
        while (!rvalid[d] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rvalid_seen", 64'(rvalid[d]), 64'd1);
        if (chk_lat) chk("rd_latency", 64'(n), 64'((d == 0 ? RDL0 : RDL1) + 1));
        held = rdata[d];
        repeat (bp) begin
            @(posedge clk);
            #1;
            chk("r_hold_vld", 64'(rvalid[d]), 64'd1);
            chk("r_hold_dat", rdata[d], held);
            chk("r_hold_arrdy", 64'(arready[d]), 64'd0);
        end
        e = rd_q.pop_front();
        chk("rdata", rdata[d], e.data);
        chk("rresp", 64'(rresp[d]), 64'(e.resp));
        rready[d] = 1'b1;
        @(posedge clk);
        #1;
        rready[d] = 1'b0;
        chk("r_done_vld", 64'(rvalid[d]), 64'd0);
        chk("r_done_arrdy", 64'(arready[d]), 64'd1);
    endtask

    // Write transaction; wvalid leads awvalid by w_lead cycles.
    task automatic wr_txn(input int d, input logic [31:0] a, input logic [63:0] data,
                          input logic [7:0] strb, input int w_lead, input bit chk_lat);
        wr_exp_t     e;
        logic [63:0] m;
        bit          aw_done, w_done, aw_hs, w_hs;
        int          t, n;
        e.resp = in_rng(a) ? 2'b00 : 2'b10;
        wr_q.push_back(e);
        if (in_rng(a)) begin
            m = model[key(d, a)];
            for (int i = 0; i < 8; i++) begin
                if (strb[i]) m[i*8 +: 8] = data[i*8 +: 8];
            end
            model[key(d, a)] = m;
        end
        awaddr[d] = a;
        wdata[d]  = data;
        wstrb[d]  = strb;
        wvalid[d] = 1'b1;
        aw_done = 1'b0;
        w_done  = 1'b0;
        t = 0;
        while (!(aw_done && w_done) && t < 100) begin
            if (t >= w_lead && !aw_done) awvalid[d] = 1'b1;
            @(negedge clk);
            aw_hs = awvalid[d] && awready[d];
            w_hs  = wvalid[d] && wready[d];
            @(posedge clk);
            #1;
            t++;
            if (aw_hs) begin
                aw_done = 1'b1;
                awvalid[d] = 1'b0;
                chk("awready_drop", 64'(awready[d]), 64'd0);
            end
            if (w_hs) begin
                w_done = 1'b1;
                wvalid[d] = 1'b0;
                chk("wready_drop", 64'(wready[d]), 64'd0);
            end
        end
        awvalid[d] = 1'b0;
        wvalid[d]  = 1'b0;
        chk("aw_w_accept_timeout", 64'(aw_done && w_done), 64'd1);
        n = 0;
        while (!bvalid[d] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bvalid_seen", 64'(bvalid[d]), 64'd1);
        if (chk_lat) chk("wr_latency", 64'(n), 64'(d == 0 ? WRL0 : WRL1));
        e = wr_q.pop_front();
        chk("bresp", 64'(bresp[d]), 64'(e.resp));
        bready[d] = 1'b1;
        @(posedge clk);
        #1;
        bready[d] = 1'b0;
        chk("b_done_vld", 64'(bvalid[d]), 64'd0);
        chk("b_done_awrdy", 64'(awready[d]), 64'd1);
        chk("b_done_wrdy", 64'(wready[d]), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no summary expected summary before timeout");
        $fatal(1);
    end

    localparam logic [31:0] W0   = BASE;
    localparam logic [31:0] W1   = BASE + 32'd8;
    localparam logic [31:0] W2   = BASE + 32'd16;
    localparam logic [31:0] W3   = BASE + 32'd24;
    localparam logic [31:0] WTOP = BASE + 32'(DEPTH * 8) - 32'd8;

    initial begin
        logic [63:0] old;
        int          n;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0;
            araddr[d] = '0; arvalid[d] = 1'b0; rready[d] = 1'b0;
            awaddr[d] = '0; awvalid[d] = 1'b0; wdata[d] = '0; wstrb[d] = '0;
            wvalid[d] = 1'b0; bready[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_arready", 64'(arready[d]), 64'd1);
            chk("rst_awready", 64'(awready[d]), 64'd1);
            chk("rst_wready", 64'(wready[d]), 64'd1);
            chk("rst_rvalid", 64'(rvalid[d]), 64'd0);
            chk("rst_bvalid", 64'(bvalid[d]), 64'd0);
            chk("rst_rdata", rdata[d], 64'd0);
            chk("rst_rresp", 64'(rresp[d]), 64'd0);
            chk("rst_bresp", 64'(bresp[d]), 64'd0);
        end
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        @(posedge clk);
        #1;

        // Basic write then read, RD_LAT=1.
        wr_txn(0, W0, 64'h1122_3344_5566_7788, 8'hFF, 0, 1'b1);
        rd_txn(0, W0, 64'h1122_3344_5566_7788, 2'b00, 0, 1'b1);

        // Byte-masked write over a zeroed word.
        wr_txn(0, W1, 64'h0, 8'hFF, 0, 1'b0);
        wr_txn(0, W1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0, 1'b1);
        rd_txn(0, W1, 64'h0000_0000_FFFF_FFFF, 2'b00, 0, 1'b0);

        // W leads AW by three cycles; exactly one bvalid pulse.
        wr_txn(0, W2, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 3, 1'b1);
        n = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bvalid[0]) n++;
        end
        chk("b_single_pulse", 64'(n), 64'd0);
        rd_txn(0, W2, exp_rd(0, W2), 2'b00, 0, 1'b0);

        // Error paths and address boundaries.
        rd_txn(0, 32'h7FFF_FFF8, 64'h0, 2'b10, 0, 1'b1);
        wr_txn(0, BASE + 32'(DEPTH * 8), 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF, 0, 1'b1);
        rd_txn(0, W0, 64'h1122_3344_5566_7788, 2'b00, 0, 1'b0);
        rd_txn(0, BASE + 32'd3, 64'h1122_3344_5566_7788, 2'b00, 0, 1'b0);
        wr_txn(0, WTOP, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 1'b0);
        rd_txn(0, WTOP, 64'h0123_4567_89AB_CDEF, 2'b00, 0, 1'b0);
        rd_txn(0, BASE + 32'(DEPTH * 8), 64'h0, 2'b10, 0, 1'b0);

        // Zero-strobe write is a no-op with OKAY.
        wr_txn(0, W1, 64'h5555_5555_5555_5555, 8'h00, 0, 1'b1);
        rd_txn(0, W1, 64'h0000_0000_FFFF_FFFF, 2'b00, 0, 1'b0);

        // Same-edge read sample and write commit: read sees old data.
        wr_txn(0, W3, 64'h1111_1111_1111_1111, 8'hFF, 0, 1'b0);
        old = exp_rd(0, W3);
        fork
            rd_txn(0, W3, old, 2'b00, 0, 1'b1);
            wr_txn(0, W3, 64'h2222_2222_2222_2222, 8'hFF, 0, 1'b1);
        join
        rd_txn(0, W3, 64'h2222_2222_2222_2222, 2'b00, 0, 1'b0);

        // RD_LAT=3 with five cycles of rready back-pressure.
        wr_txn(1, W0, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 0, 1'b1);
        rd_txn(1, W0, 64'hA5A5_5A5A_0F0F_F0F0, 2'b00, 5, 1'b1);

        // Reset while the read is waiting: abandoned, no response.
        araddr[1]  = W0;
        arvalid[1] = 1'b1;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (arready[1]) break;
            n++;
        end
        @(posedge clk);
        #1;
        arvalid[1] = 1'b0;
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_rvalid", 64'(rvalid[1]), 64'd0);
        chk("midrst_arready", 64'(arready[1]), 64'd1);
        rst[1] = 1'b1;
        n = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (rvalid[1]) n++;
        end
        chk("midrst_no_resp", 64'(n), 64'd0);
        // RAM contents survive reset.
        rd_txn(1, W0, 64'hA5A5_5A5A_0F0F_F0F0, 2'b00, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
